// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, direction constants and BCD helper
package elevator_pkg;
    typedef enum logic [2:0] {IDLE, MOVE, STEP, SETTLE, DOOR, HALT} state_t;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
    function automatic logic [6:0] bcd2bin(input logic [3:0] t, input logic [3:0] o);
        return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, o};
    endfunction
endpackage

// File: rtl/elevator_motion_ctrl_timer.sv
// elev_timer: loadable down-counter, o_done while the count is zero
module elev_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    // load on request, otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl: request handshake, trip pacing and door timing for the BCD floor counter (optional ELEV_ESTOP_EN adds estop/HALT)
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int STEP_CYCLES = 16,
    parameter int DOOR_CYCLES = 32,
    parameter int MIN_FLOOR   = 0,
    parameter int MAX_FLOOR   = 99
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ELEV_ESTOP_EN
    input  logic       estop,
`endif
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_tens,
    input  logic [3:0] req_ones,
    input  logic [3:0] cur_tens,
    input  logic [3:0] cur_ones,
    output logic       en_n,
    output logic       du,
    output logic       door_open,
    output logic       moving,
    output logic       arrived,
    output logic       req_err
);
    state_t     r_state, w_next;
    logic [6:0] r_target;
    logic       r_du, r_ready, r_arrived, r_req_err;
    logic       w_arr, w_err, w_ld_step, w_ld_door, w_step_done, w_door_done;
    logic [6:0] w_req, w_cur;
    logic       w_req_ok, w_at_lim, w_take;
    logic       w_halt;
`ifdef ELEV_ESTOP_EN
    logic       r_trip;
    assign w_halt = estop;
`else
    assign w_halt = 1'b0;
`endif

    assign w_req    = bcd2bin(req_tens, req_ones);
    assign w_cur    = bcd2bin(cur_tens, cur_ones);
    assign w_req_ok = (req_tens <= 4'd9) && (req_ones <= 4'd9) && (w_req <= 7'(MAX_FLOOR))
                      && (({1'b0, w_req} + 8'd1) > 8'(MIN_FLOOR));
    assign w_at_lim = r_du ? ({1'b0, w_cur} < (8'(MIN_FLOOR) + 8'd1)) : (w_cur >= 7'(MAX_FLOOR));
    assign w_take   = (r_state == IDLE) && req_valid && req_ready;

    elev_timer #(.W(8)) u_step (
        .clk(clk), .rst(rst), .i_load(w_ld_step), .i_val(8'(STEP_CYCLES - 2)), .o_done(w_step_done)
    );
    elev_timer #(.W(8)) u_door (
        .clk(clk), .rst(rst), .i_load(w_ld_door), .i_val(8'(DOOR_CYCLES - 1)), .o_done(w_door_done)
    );

    // next-state, event pulses and timer loads; estop overrides everything
    always_comb begin
        w_next = r_state;
        w_arr  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE:
                if (w_take) begin
                    if (!w_req_ok) w_err = 1'b1;
                    else if (w_req == w_cur) begin w_next = DOOR; w_arr = 1'b1; end
                    else w_next = MOVE;
                end
            MOVE:
                if (w_step_done) begin
                    if (w_cur == r_target) begin w_next = DOOR; w_arr = 1'b1; end
                    else if (w_at_lim) begin w_next = DOOR; w_err = 1'b1; end
                    else w_next = STEP;
                end
            STEP:   w_next = SETTLE;
            SETTLE:
                if (w_cur == r_target) begin w_next = DOOR; w_arr = 1'b1; end
                else w_next = MOVE;
            DOOR:   w_next = w_door_done ? IDLE : DOOR;
`ifdef ELEV_ESTOP_EN
            HALT:   w_next = estop ? HALT : (r_trip ? MOVE : IDLE);
`endif
            default: w_next = IDLE;
        endcase
        if (w_halt) begin
            w_next = HALT;
            w_arr  = 1'b0;
            w_err  = 1'b0;
        end
        w_ld_step = (w_next == MOVE) && (r_state != MOVE);
        w_ld_door = (w_next == DOOR) && (r_state != DOOR);
    end

    // state, target, trip direction and registered pulses
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state   <= IDLE;
            r_target  <= '0;
            r_du      <= DIR_UP;
            r_ready   <= 1'b0;
            r_arrived <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == IDLE);
            r_arrived <= w_arr;
            r_req_err <= w_err;
            if (w_take) r_target <= w_req;
            if ((r_state == IDLE) && (w_next == MOVE)) r_du <= (w_req < w_cur) ? DIR_DN : DIR_UP;
        end

`ifdef ELEV_ESTOP_EN
    // remembers whether HALT interrupted a trip so it can resume
    always_ff @(posedge clk or posedge rst)
        if (rst) r_trip <= 1'b0;
        else if (r_state != HALT) r_trip <= (r_state == MOVE) || (r_state == STEP) || (r_state == SETTLE);
`endif

    assign en_n      = (r_state != STEP) || w_halt;
    assign du        = r_du;
    assign door_open = (r_state == DOOR);
    assign moving    = (r_state == MOVE) || (r_state == STEP) || (r_state == SETTLE);
    assign arrived   = r_arrived;
    assign req_err   = r_req_err;
    assign req_ready = r_ready && !w_halt;
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb_elevator_motion_ctrl: table-driven trip vectors plus reset/estop sequences against a BCD counter model
module tb_elevator_motion_ctrl;
    localparam int STEP = 4;
    localparam int DOOR = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic [3:0] req_tens = 4'd0, req_ones = 4'd0;
    logic [3:0] ct = 4'd0, co = 4'd0;
    logic [3:0] set_t = 4'd0, set_o = 4'd0;
    logic set_en = 1'b0;
    logic req_ready, en_n, du, door_open, moving, arrived, req_err;
`ifdef ELEV_ESTOP_EN
    logic estop = 1'b0;
`endif

    int n_cmp = 0, n_fail = 0;
    int m_err, m_steps, m_arr, m_arr_cnt, m_door, m_du, m_bad, m_to;

    typedef struct {
        logic [3:0] st, so, rt, ro;
        int err, du, steps, arr, door, fin;
    } vec_t;
    vec_t vecs[10];

    elevator_motion_ctrl #(.STEP_CYCLES(STEP), .DOOR_CYCLES(DOOR), .MIN_FLOOR(0), .MAX_FLOOR(50)) dut (
        .clk(clk),
        .rst(rst),
`ifdef ELEV_ESTOP_EN
        .estop(estop),
`endif
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_tens(req_tens),
        .req_ones(req_ones),
        .cur_tens(ct),
        .cur_ones(co),
        .en_n(en_n),
        .du(du),
        .door_open(door_open),
        .moving(moving),
        .arrived(arrived),
        .req_err(req_err)
    );

    always #5 clk = ~clk;

    // two-digit BCD floor counter model, stepping on the falling edge while en_n is low
    always @(negedge clk) begin
        if (set_en) begin
            ct <= set_t;
            co <= set_o;
        end else if (!en_n) begin
            if (!du) begin
                if (co == 4'd9) begin co <= 4'd0; ct <= ct + 4'd1; end
                else co <= co + 4'd1;
            end else begin
                if (co == 4'd0) begin co <= 4'd9; ct <= ct - 4'd1; end
                else co <= co - 4'd1;
            end
        end
    end

    function automatic int floor_now();
        return int'(ct) * 10 + int'(co);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preset(input logic [3:0] st, input logic [3:0] so);
        set_t = st;
        set_o = so;
        set_en = 1'b1;
        @(posedge clk); #1;
        set_en = 1'b0;
    endtask

    task automatic run(input logic [3:0] st, input logic [3:0] so, input logic [3:0] rt, input logic [3:0] ro);
        int last;
        logic prev_low;
        m_err = 0; m_steps = 0; m_arr = 0; m_arr_cnt = 0; m_door = 0; m_du = -1; m_bad = 0; m_to = 1;
        preset(st, so);
        chk("ready_before_req", int'(req_ready), 1);
        req_tens = rt;
        req_ones = ro;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        last = 0;
        prev_low = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            m_err += int'(req_err);
            m_door += int'(door_open);
            if (arrived) begin
                m_arr_cnt++;
                if (m_arr == 0) m_arr = c;
            end
            if (!en_n) begin
                if (prev_low) m_bad++;
                if (c - last != (m_steps == 0 ? STEP : STEP + 1)) m_bad++;
                if (m_du < 0) m_du = int'(du);
                m_steps++;
                last = c;
            end
            if (moving && m_du >= 0 && int'(du) != m_du) m_bad++;
            prev_low = !en_n;
            if (req_ready) begin
                m_to = 0;
                break;
            end
        end
        chk("trip_timeout", m_to, 0);
    endtask

    initial begin
        vecs[0] = '{4'd2, 4'd0, 4'd2, 4'd3, 0,  0,  3, 16, DOOR, 23};
        vecs[1] = '{4'd1, 4'd0, 4'd0, 4'd9, 0,  1,  1,  6, DOOR,  9};
        vecs[2] = '{4'd0, 4'd5, 4'd0, 4'd5, 0, -1,  0,  1, DOOR,  5};
        vecs[3] = '{4'd0, 4'd5, 4'hA, 4'd0, 1, -1,  0,  0,    0,  5};
        vecs[4] = '{4'd0, 4'd5, 4'd9, 4'd9, 1, -1,  0,  0,    0,  5};
        vecs[5] = '{4'd0, 4'd5, 4'd5, 4'd1, 1, -1,  0,  0,    0,  5};
        vecs[6] = '{4'd4, 4'd8, 4'd5, 4'd0, 0,  0,  2, 11, DOOR, 50};
        vecs[7] = '{4'd0, 4'd2, 4'd0, 4'd0, 0,  1,  2, 11, DOOR,  0};
        vecs[8] = '{4'd0, 4'd7, 4'd0, 4'hF, 1, -1,  0,  0,    0,  7};
        vecs[9] = '{4'd3, 4'd0, 4'd1, 4'd5, 0,  1, 15, 76, DOOR, 15};

        #3;
        chk("rst_en_n", int'(en_n), 1);
        chk("rst_du", int'(du), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_arrived", int'(arrived), 0);
        chk("rst_req_err", int'(req_err), 0);
        chk("rst_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        chk("rst_ready_held", int'(req_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", int'(req_ready), 1);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].st, vecs[i].so, vecs[i].rt, vecs[i].ro);
            chk($sformatf("v%0d_err", i), m_err, vecs[i].err);
            chk($sformatf("v%0d_steps", i), m_steps, vecs[i].steps);
            chk($sformatf("v%0d_arr_cycle", i), m_arr, vecs[i].arr);
            chk($sformatf("v%0d_arr_count", i), m_arr_cnt, vecs[i].err == 0 ? 1 : 0);
            chk($sformatf("v%0d_door", i), m_door, vecs[i].door);
            chk($sformatf("v%0d_floor", i), floor_now(), vecs[i].fin);
            chk($sformatf("v%0d_pulse_shape", i), m_bad, 0);
            if (vecs[i].du >= 0) chk($sformatf("v%0d_du", i), m_du, vecs[i].du);
        end

        begin : rst_in_step
            int found;
            found = 0;
            preset(4'd2, 4'd0);
            req_tens = 4'd2;
            req_ones = 4'd3;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                if (!en_n) begin found = 1; break; end
            end
            chk("step_seen", found, 1);
            rst = 1'b1;
            #1;
            chk("async_en_n", int'(en_n), 1);
            chk("async_moving", int'(moving), 0);
            chk("async_ready", int'(req_ready), 0);
            chk("async_du", int'(du), 0);
            chk("async_door", int'(door_open), 0);
            @(negedge clk); #1;
            chk("no_step_in_rst", floor_now(), 20);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            chk("ready_after_rst2", int'(req_ready), 1);
            chk("en_n_after_rst2", int'(en_n), 1);
        end

`ifdef ELEV_ESTOP_EN
        begin : estop_seq
            int steps, arr, bad, done;
            steps = 0; arr = 0; bad = 0; done = 0;
            preset(4'd2, 4'd0);
            req_tens = 4'd2;
            req_ones = 4'd5;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int c = 1; c <= 6; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                if (!en_n) steps++;
            end
            estop = 1'b1;
            #1;
            chk("estop_force_en_n", int'(en_n), 1);
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (!en_n || moving || door_open || req_ready) bad++;
            end
            chk("estop_halt_outputs", bad, 0);
            chk("estop_floor_held", floor_now(), 21);
            estop = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #1;
                if (!en_n) begin
                    steps++;
                    if (du) bad++;
                end
                if (arrived) arr++;
                if (req_ready) begin done = 1; break; end
            end
            chk("estop_done", done, 1);
            chk("estop_steps", steps, 5);
            chk("estop_arrived", arr, 1);
            chk("estop_du_const", bad, 0);
            chk("estop_floor", floor_now(), 25);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
